// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the ALU issue bundle.
// Used by the issue stage and its immediate generator.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD_SUB     = 3'b000;
    localparam logic [2:0] ALU_SHIFT_LEFT  = 3'b001;
    localparam logic [2:0] ALU_SLT         = 3'b010;
    localparam logic [2:0] ALU_SLTU        = 3'b011;
    localparam logic [2:0] ALU_XOR         = 3'b100;
    localparam logic [2:0] ALU_SHIFT_RIGHT = 3'b101;
    localparam logic [2:0] ALU_OR          = 3'b110;
    localparam logic [2:0] ALU_AND         = 3'b111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic [31:0] bits_a;
        logic [31:0] bits_b;
        logic [9:0]  func;
        logic        is_branch;
        logic [4:0]  rd;
        logic [31:0] store_data;
        logic        illegal;
    } issue_t;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator; all immediates sign-extend from instr[31].
// Opcode bits are not needed, so only instr[31:7] is taken.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_type_e   sel,
    output logic [31:0] imm
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    always_comb begin
        imm = imm_i;
        unique case (sel)
            IMM_I:   imm = imm_i;
            IMM_S:   imm = imm_s;
            IMM_B:   imm = imm_b;
            IMM_U:   imm = imm_u;
            IMM_J:   imm = imm_j;
            default: imm = imm_i;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: forms operands/func from a register-read bundle and
// presents them from a registered output backed by a one-entry skid.
module alu_issue_stage
    import riscv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_bits_a,
    output logic [XLEN-1:0] out_bits_b,
    output logic [9:0]      out_func,
    output logic            out_is_branch,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm;
    imm_type_e   imm_sel;
    issue_t      nxt;

    logic is_op;
    logic is_op_imm;
    logic is_lui;
    logic is_auipc;
    logic is_jump;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_shift;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rd     = in_instr[11:7];

    assign is_op     = (opcode == OPC_OP);
    assign is_op_imm = (opcode == OPC_OP_IMM);
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_shift  = (funct3 == ALU_SHIFT_LEFT) ||
                       (funct3 == ALU_SHIFT_RIGHT);

    always_comb begin
        imm_sel = IMM_I;
        unique case (1'b1)
            is_store:           imm_sel = IMM_S;
            is_lui || is_auipc: imm_sel = IMM_U;
            is_branch:          imm_sel = IMM_B;
            default:            imm_sel = IMM_I;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .sel   (imm_sel),
        .imm   (imm)
    );

    always_comb begin
        nxt = '0;
        unique case (1'b1)
            is_op: begin
                nxt.bits_a = in_rs1;
                nxt.bits_b = in_rs2;
                // The ALU only adds, so SUB issues the two's complement of rs2.
                if (funct7[5] && funct3 == ALU_ADD_SUB)
                    nxt.bits_b = ~in_rs2 + 32'd1;
                nxt.func = {funct7, funct3};
                nxt.rd   = rd;
            end
            is_op_imm: begin
                nxt.bits_a = in_rs1;
                if (is_shift) begin
                    nxt.bits_b = {27'b0, in_instr[24:20]};
                    nxt.func   = {funct7, funct3};
                end else begin
                    nxt.bits_b = imm;
                    nxt.func   = {7'b0, funct3};
                end
                nxt.rd = rd;
            end
            is_lui: begin
                nxt.bits_b = imm;
                nxt.rd     = rd;
            end
            is_auipc: begin
                nxt.bits_a = in_pc;
                nxt.bits_b = imm;
                nxt.rd     = rd;
            end
            is_jump: begin
                nxt.bits_a = in_pc;
                nxt.bits_b = XLEN'(PC_STEP);
                nxt.rd     = rd;
            end
            is_load: begin
                nxt.bits_a = in_rs1;
                nxt.bits_b = imm;
                nxt.rd     = rd;
            end
            is_store: begin
                nxt.bits_a     = in_rs1;
                nxt.bits_b     = imm;
                nxt.store_data = in_rs2;
            end
            is_branch: begin
                nxt.bits_a    = in_rs1;
                nxt.bits_b    = in_rs2;
                nxt.func      = {7'b0, funct3};
                nxt.is_branch = 1'b1;
            end
            default: begin
                nxt.illegal = 1'b1;
            end
        endcase
    end

    issue_t out_q;
    issue_t skid_q;
    logic   out_v;
    logic   skid_v;
    logic   accept;
    logic   fire;

    assign in_ready = ~skid_v;
    assign accept   = in_valid & in_ready;
    assign fire     = out_v & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (!out_v || fire) begin
            if (skid_v) begin
                out_q <= skid_q;
                out_v <= 1'b1;
                if (accept) skid_q <= nxt;
                else        skid_v <= 1'b0;
            end else if (accept) begin
                out_q <= nxt;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (accept) begin
            skid_q <= nxt;
            skid_v <= 1'b1;
        end
    end

    assign out_valid      = out_v;
    assign out_bits_a     = out_q.bits_a;
    assign out_bits_b     = out_q.bits_b;
    assign out_func       = out_q.func;
    assign out_is_branch  = out_q.is_branch;
    assign out_rd         = out_q.rd;
    assign out_store_data = out_q.store_data;
    assign out_illegal    = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, handshake, flush, reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_issue_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_bits_a;
    logic [31:0] out_bits_b;
    logic [9:0]  out_func;
    logic        out_is_branch;
    logic [4:0]  out_rd;
    logic [31:0] out_store_data;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_bits_a     (out_bits_a),
        .out_bits_b     (out_bits_b),
        .out_func       (out_func),
        .out_is_branch  (out_is_branch),
        .out_rd         (out_rd),
        .out_store_data (out_store_data),
        .out_illegal    (out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_type(input logic [11:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] b_type(input logic [12:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11],
                OPC_BRANCH};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        in_rs1   = rs1;
        in_rs2   = rs2;
    endtask

    // One bundle through with out_ready=1; leaves outputs at the negedge.
    task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        @(negedge clk);
        drive(instr, pc, rs1, rs2);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        out_ready = 1'b1;

        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_a", out_bits_a, 32'd0);
        check("rst_b", out_bits_b, 32'd0);
        check("rst_func", 32'(out_func), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'h100, 32'd5, 32'd7);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_a", out_bits_a, 32'd5);
        check("add_b", out_bits_b, 32'd7);
        check("add_func", 32'(out_func), 32'h000);
        check("add_rd", 32'(out_rd), 32'd3);

        issue(r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 32'h104, 32'd10, 32'd3);
        check("sub_b", out_bits_b, 32'hFFFF_FFFD);
        check("sub_func", 32'(out_func), 32'h100);
        check("sub_sum", out_bits_a + out_bits_b, 32'd7);

        issue(r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 32'h104, 32'd9, 32'd0);
        check("sub0_b", out_bits_b, 32'd0);

        issue(i_type(12'h404, 5'd6, 3'b101, 5'd5, OPC_OP_IMM), 32'h108,
              32'h8000_0000, 32'd0);
        check("srai_func", 32'(out_func), 32'h105);
        check("srai_b", out_bits_b, 32'd4);
        check("srai_a", out_bits_a, 32'h8000_0000);

        issue(i_type(12'hFFF, 5'd1, 3'b000, 5'd7, OPC_OP_IMM), 32'h10C,
              32'd1, 32'd0);
        check("addi_b", out_bits_b, 32'hFFFF_FFFF);
        check("addi_func", 32'(out_func), 32'h000);

        issue(b_type(13'h010, 5'd2, 5'd1, BR_LT), 32'h110,
              32'hFFFF_FFFE, 32'd1);
        check("blt_br", 32'(out_is_branch), 32'd1);
        check("blt_func", 32'(out_func), 32'h004);
        check("blt_rd", 32'(out_rd), 32'd0);
        check("blt_a", out_bits_a, 32'hFFFF_FFFE);
        check("blt_b", out_bits_b, 32'd1);

        issue(32'hFFFF_FFFF, 32'h114, 32'd11, 32'd12);
        check("ill_flag", 32'(out_illegal), 32'd1);
        check("ill_valid", 32'(out_valid), 32'd1);
        check("ill_a", out_bits_a, 32'd0);
        check("ill_b", out_bits_b, 32'd0);
        check("ill_func", 32'(out_func), 32'd0);
        check("ill_rd", 32'(out_rd), 32'd0);

        issue(s_type(12'hFF8, 5'd2, 5'd1, 3'b010), 32'h118,
              32'h1000, 32'hCAFE_F00D);
        check("sw_a", out_bits_a, 32'h1000);
        check("sw_b", out_bits_b, 32'hFFFF_FFF8);
        check("sw_data", out_store_data, 32'hCAFE_F00D);
        check("sw_rd", 32'(out_rd), 32'd0);

        issue({20'hABCDE, 5'd9, OPC_LUI}, 32'h11C, 32'd1, 32'd2);
        check("lui_a", out_bits_a, 32'd0);
        check("lui_b", out_bits_b, 32'hABCD_E000);

        issue({20'h80001, 5'd9, OPC_AUIPC}, 32'h120, 32'd1, 32'd2);
        check("auipc_a", out_bits_a, 32'h120);
        check("auipc_b", out_bits_b, 32'h8000_1000);

        issue({20'h00000, 5'd1, OPC_JAL}, 32'h124, 32'd1, 32'd2);
        check("jal_a", out_bits_a, 32'h124);
        check("jal_b", out_bits_b, 32'd4);
        check("jal_rd", 32'(out_rd), 32'd1);

        issue(i_type(12'h010, 5'd1, 3'b010, 5'd8, OPC_LOAD), 32'h128,
              32'h2000, 32'd0);
        check("lw_b", out_bits_b, 32'd16);
        check("lw_func", 32'(out_func), 32'd0);

        @(negedge clk);
        check("drain", 32'(out_valid), 32'd0);

        // Back-to-back with continuous out_ready: one per cycle.
        drive(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 32'd21, 32'd0);
        @(negedge clk);
        check("tp1", out_bits_a, 32'd21);
        in_rs1 = 32'd22;
        @(negedge clk);
        check("tp2", out_bits_a, 32'd22);
        check("tp2_v", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("tp_end", 32'(out_valid), 32'd0);

        // Backpressure: b1 in output, b2 in skid, b3 waits.
        out_ready = 1'b0;
        drive(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 32'd1, 32'd0);
        @(negedge clk);
        check("bp_b1", out_bits_a, 32'd1);
        check("bp_rdy1", 32'(in_ready), 32'd1);
        in_rs1 = 32'd2;
        @(negedge clk);
        check("bp_hold1", out_bits_a, 32'd1);
        check("bp_rdy0", 32'(in_ready), 32'd0);
        in_rs1 = 32'd3;
        @(negedge clk);
        check("bp_hold2", out_bits_a, 32'd1);
        check("bp_rdy0b", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_b2", out_bits_a, 32'd2);
        check("bp_v2", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_b3", out_bits_a, 32'd3);
        check("bp_v3", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("bp_end", 32'(out_valid), 32'd0);

        // Flush with skid full and a bundle still offered.
        out_ready = 1'b0;
        drive(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 32'd4, 32'd0);
        @(negedge clk);
        in_rs1 = 32'd5;
        @(negedge clk);
        check("fl_full", 32'(in_ready), 32'd0);
        in_rs1 = 32'd6;
        flush  = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fl_quiet", 32'(out_valid), 32'd0);
        end

        // Flush while accepting into an empty stage discards the bundle.
        drive(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 32'd7, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_acc", 32'(out_valid), 32'd0);

        // Asynchronous reset while holding a bundle.
        out_ready = 1'b0;
        drive(r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 32'd9, 32'd8);
        @(negedge clk);
        in_valid = 1'b0;
        check("ar_pre", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_a", out_bits_a, 32'd0);
        check("ar_b", out_bits_b, 32'd0);
        check("ar_rd", 32'(out_rd), 32'd0);
        check("ar_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
